// File: rtl/oled_pkg.sv
// Shared types and default timing for the PMOD OLEDrgb controller.
// Optional power-down path is enabled by defining OLED_PWRDN_EN.
package oled_pkg;

   localparam int unsigned T_VDD_CYC_DEF = 20000;
   localparam int unsigned T_RES_CYC_DEF = 3;
   localparam int unsigned SCK_DIV_DEF   = 2;
   localparam int unsigned CNT_W_DEF     = 15;
   localparam int unsigned SPI_BITS      = 8;

   typedef enum logic [2:0] {
      PWR_OFF,
      PWR_VDD_WAIT,
      PWR_RST_LO,
      PWR_RST_HI,
      PWR_READY
`ifdef OLED_PWRDN_EN
      , PWR_DN
`endif
   } pwr_state_e;

   typedef enum logic [1:0] {
      SPI_IDLE,
      SPI_LOAD,
      SPI_SHIFT,
      SPI_GAP
   } spi_state_e;

endpackage

// File: rtl/oled_pmod_ctrl_if.sv
// Byte push handshake between the MCU bus decode and the OLED controller.
interface oled_pmod_ctrl_if;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       tx_dc;
   logic       tx_ready;

   modport master (output tx_valid, tx_data, tx_dc, input tx_ready);
   modport slave  (input tx_valid, tx_data, tx_dc, output tx_ready);
endinterface

// File: rtl/oled_spi_tx.sv
// SPI mode-0 byte shifter with SCK divider, CS framing and D/C.
// Accepts a byte when valid_i & rdy_o; all pin outputs are registered.
module oled_spi_tx
   import oled_pkg::*;
#(
   parameter int unsigned SCK_DIV = SCK_DIV_DEF,
   parameter int unsigned CNT_W   = CNT_W_DEF
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       allow_i,
   input  logic       valid_i,
   input  logic [7:0] data_i,
   input  logic       dc_i,
   output logic       rdy_o,
   output logic       quiet_o,
   output logic       cs_o,
   output logic       sck_o,
   output logic       pico_o,
   output logic       dc_o
);

   localparam int unsigned       HP_W     = $clog2(2 * SPI_BITS);
   localparam logic [HP_W-1:0]   HP_LAST  = HP_W'(2 * SPI_BITS - 1);
   localparam logic [CNT_W-1:0]  DIV_LOAD = CNT_W'(SCK_DIV - 1);

   spi_state_e          st_q, st_d;
   logic [HP_W-1:0]     hp_q, hp_d;
   logic [CNT_W-1:0]    div_q, div_d;
   logic [SPI_BITS-1:0] sreg_q, sreg_d;
   logic                rdy_q, rdy_d;
   logic                cs_q, cs_d;
   logic                sck_q, sck_d;
   logic                pico_q, pico_d;
   logic                dc_q, dc_d;
   logic                free;
   logic                accept;

   // The tail of the CS-high gap counts as free so back-to-back bytes need no extra cycle
   assign free   = (st_q == SPI_IDLE) || ((st_q == SPI_GAP) && (div_q == '0));
   assign accept = valid_i & rdy_q;

   always_comb begin
      st_d   = st_q;
      hp_d   = hp_q;
      div_d  = div_q;
      sreg_d = sreg_q;
      cs_d   = cs_q;
      sck_d  = sck_q;
      pico_d = pico_q;
      dc_d   = dc_q;
      case (st_q)
         SPI_LOAD: begin
            st_d   = SPI_SHIFT;
            hp_d   = '0;
            div_d  = DIV_LOAD;
            cs_d   = 1'b0;
            sck_d  = 1'b0;
            pico_d = sreg_q[SPI_BITS-1];
         end
         SPI_SHIFT: begin
            if (div_q != '0) begin
               div_d = div_q - CNT_W'(1);
            end else begin
               div_d = DIV_LOAD;
               if (hp_q == HP_LAST) begin
                  st_d  = SPI_GAP;
                  sck_d = 1'b0;
                  cs_d  = 1'b1;
               end else begin
                  hp_d  = hp_q + HP_W'(1);
                  sck_d = ~hp_q[0];
                  if (hp_q[0]) begin
                     sreg_d = sreg_q << 1;
                     pico_d = sreg_q[SPI_BITS-2];
                  end
               end
            end
         end
         SPI_GAP: begin
            if (div_q != '0) div_d = div_q - CNT_W'(1);
         end
         default: ;
      endcase
      if (free) begin
         if (accept) begin
            st_d   = SPI_LOAD;
            sreg_d = data_i;
            dc_d   = dc_i;
         end else begin
            st_d   = SPI_IDLE;
         end
      end
      rdy_d = allow_i && ((st_d == SPI_IDLE) || ((st_d == SPI_GAP) && (div_d == '0)));
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         st_q   <= SPI_IDLE;
         hp_q   <= '0;
         div_q  <= '0;
         sreg_q <= '0;
         rdy_q  <= 1'b0;
         cs_q   <= 1'b1;
         sck_q  <= 1'b0;
         pico_q <= 1'b0;
         dc_q   <= 1'b0;
      end else begin
         st_q   <= st_d;
         hp_q   <= hp_d;
         div_q  <= div_d;
         sreg_q <= sreg_d;
         rdy_q  <= rdy_d;
         cs_q   <= cs_d;
         sck_q  <= sck_d;
         pico_q <= pico_d;
         dc_q   <= dc_d;
      end
   end

   assign rdy_o   = rdy_q;
   assign quiet_o = free & ~accept;
   assign cs_o    = cs_q;
   assign sck_o   = sck_q;
   assign pico_o  = pico_q;
   assign dc_o    = dc_q;

endmodule

// File: rtl/oled_pmod_ctrl.sv
// PMOD OLEDrgb controller: power sequencing FSM plus SPI byte transmitter.
// Define OLED_PWRDN_EN to add the en-driven power-down state.
module oled_pmod_ctrl
   import oled_pkg::*;
#(
   parameter int unsigned T_VDD_CYC = T_VDD_CYC_DEF,
   parameter int unsigned T_RES_CYC = T_RES_CYC_DEF,
   parameter int unsigned SCK_DIV   = SCK_DIV_DEF,
   parameter int unsigned CNT_W     = CNT_W_DEF
) (
   input  logic            clk0,
   input  logic            rst,
   input  logic            en,
   input  logic            vcc_on,
   oled_pmod_ctrl_if.slave tx,
   output logic            pwr_ok,
   output logic            pmod_cs,
   output logic            pmod_sck,
   output logic            pmod_pico,
   output logic            pmod_dc,
   output logic            pmod_res,
   output logic            pmod_vccen,
   output logic            pmod_pmoden
);

   localparam logic [CNT_W-1:0] VDD_LOAD = CNT_W'(T_VDD_CYC - 1);
   localparam logic [CNT_W-1:0] RES_LOAD = CNT_W'(T_RES_CYC - 1);

   pwr_state_e       state_q, state_d;
   logic [CNT_W-1:0] tmr_q, tmr_d;
   logic             pwr_ok_q, pwr_ok_d;
   logic             res_q, res_d;
   logic             vccen_q, vccen_d;
   logic             pmoden_q, pmoden_d;
   logic             spi_allow;
   logic             spi_rdy;
   logic             spi_quiet;

`ifndef OLED_PWRDN_EN
   logic unused_spi_quiet;
   assign unused_spi_quiet = spi_quiet;
`endif

   // Pin outputs are derived from the next state so they line up with state_q
   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      case (state_q)
         PWR_OFF: begin
            if (en) begin
               state_d = PWR_VDD_WAIT;
               tmr_d   = VDD_LOAD;
            end
         end
         PWR_VDD_WAIT: begin
            if (tmr_q != '0) tmr_d = tmr_q - CNT_W'(1);
            else begin
               state_d = PWR_RST_LO;
               tmr_d   = RES_LOAD;
            end
         end
         PWR_RST_LO: begin
            if (tmr_q != '0) tmr_d = tmr_q - CNT_W'(1);
            else begin
               state_d = PWR_RST_HI;
               tmr_d   = RES_LOAD;
            end
         end
         PWR_RST_HI: begin
            if (tmr_q != '0) tmr_d = tmr_q - CNT_W'(1);
            else state_d = PWR_READY;
         end
`ifdef OLED_PWRDN_EN
         PWR_READY: begin
            if (!en && spi_quiet) begin
               state_d = PWR_DN;
               tmr_d   = VDD_LOAD;
            end
         end
         PWR_DN: begin
            if (tmr_q != '0) tmr_d = tmr_q - CNT_W'(1);
            else state_d = PWR_OFF;
         end
`endif
         default: ;
      endcase

      spi_allow = (state_d == PWR_READY);
      pwr_ok_d  = (state_d == PWR_READY);
      pmoden_d  = (state_d != PWR_OFF);
      vccen_d   = (state_d == PWR_READY) && vcc_on;
      res_d     = (state_d == PWR_RST_HI) || (state_d == PWR_READY)
`ifdef OLED_PWRDN_EN
                  || (state_d == PWR_DN)
`endif
                  ;
   end

   always_ff @(posedge clk0) begin
      if (rst) begin
         state_q  <= PWR_OFF;
         tmr_q    <= '0;
         pwr_ok_q <= 1'b0;
         res_q    <= 1'b0;
         vccen_q  <= 1'b0;
         pmoden_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         tmr_q    <= tmr_d;
         pwr_ok_q <= pwr_ok_d;
         res_q    <= res_d;
         vccen_q  <= vccen_d;
         pmoden_q <= pmoden_d;
      end
   end

   oled_spi_tx #(
      .SCK_DIV (SCK_DIV),
      .CNT_W   (CNT_W)
   ) u_spi (
      .clk_i   (clk0),
      .rst_i   (rst),
      .allow_i (spi_allow),
      .valid_i (tx.tx_valid),
      .data_i  (tx.tx_data),
      .dc_i    (tx.tx_dc),
      .rdy_o   (spi_rdy),
      .quiet_o (spi_quiet),
      .cs_o    (pmod_cs),
      .sck_o   (pmod_sck),
      .pico_o  (pmod_pico),
      .dc_o    (pmod_dc)
   );

   assign tx.tx_ready   = spi_rdy;
   assign pwr_ok        = pwr_ok_q;
   assign pmod_res      = res_q;
   assign pmod_vccen    = vccen_q;
   assign pmod_pmoden   = pmoden_q;

endmodule

// File: tb/tb_oled_pmod_ctrl.sv
// Randomised bench for oled_pmod_ctrl against a timeline-based reference model.
// Power-down expectations follow OLED_PWRDN_EN when it is defined.
module tb_oled_pmod_ctrl;

   localparam int T_VDD = 20;
   localparam int T_RES = 3;
   localparam int DIV   = 2;

   logic clk0 = 1'b0;
   logic rst, en, vcc_on;
   logic pwr_ok, pmod_cs, pmod_sck, pmod_pico, pmod_dc, pmod_res, pmod_vccen, pmod_pmoden;

   oled_pmod_ctrl_if tx_if ();

   oled_pmod_ctrl #(
      .T_VDD_CYC (T_VDD),
      .T_RES_CYC (T_RES),
      .SCK_DIV   (DIV),
      .CNT_W     (15)
   ) dut (
      .clk0        (clk0),
      .rst         (rst),
      .en          (en),
      .vcc_on      (vcc_on),
      .tx          (tx_if.slave),
      .pwr_ok      (pwr_ok),
      .pmod_cs     (pmod_cs),
      .pmod_sck    (pmod_sck),
      .pmod_pico   (pmod_pico),
      .pmod_dc     (pmod_dc),
      .pmod_res    (pmod_res),
      .pmod_vccen  (pmod_vccen),
      .pmod_pmoden (pmod_pmoden)
   );

   always #5 clk0 = ~clk0;

   int n_chk  = 0;
   int n_fail = 0;
   int edge_n = 0;

   // Reference model: event edges on an absolute timeline
   int         en_edge  = -1;
   int         pd_edge  = -1;
   int         acc_edge = -1;
   logic [7:0] acc_byte = '0;
   logic       acc_dc   = 1'b0;
   logic       vcc_s    = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s at edge %0d: got %0h expected %0h", tag, edge_n, obs, exp);
      end
   endtask

   function automatic bit m_pwr_ready(input int k);
      return (en_edge >= 0) && (k >= en_edge + T_VDD + 2 * T_RES) && !((pd_edge >= 0) && (k >= pd_edge));
   endfunction

   function automatic bit m_rdy(input int k);
      return m_pwr_ready(k) && ((acc_edge < 0) || (k >= acc_edge + 17 * DIV));
   endfunction

   task automatic model_edge();
      bit prev_rdy, was_off, acc;
      prev_rdy = m_rdy(edge_n - 1);
      if (rst) begin
         en_edge  = -1;
         pd_edge  = -1;
         acc_edge = -1;
         acc_byte = '0;
         acc_dc   = 1'b0;
         vcc_s    = 1'b0;
      end else begin
         was_off = (en_edge < 0);
         acc     = tx_if.tx_valid && prev_rdy;
         if (acc) begin
            acc_edge = edge_n;
            acc_byte = tx_if.tx_data;
            acc_dc   = tx_if.tx_dc;
         end
`ifdef OLED_PWRDN_EN
         if ((pd_edge >= 0) && (edge_n == pd_edge + T_VDD)) begin
            en_edge = -1;
            pd_edge = -1;
         end else if ((pd_edge < 0) && prev_rdy && !en && !acc) begin
            pd_edge = edge_n;
         end
`endif
         if (was_off && en) en_edge = edge_n;
         vcc_s = vcc_on;
      end
   endtask

   task automatic compare();
      int   j;
      logic e_cs, e_sck;
      e_cs  = 1'b1;
      e_sck = 1'b0;
      if (acc_edge >= 0) begin
         j = edge_n - acc_edge - 1;
         if ((j >= 0) && (j < 16 * DIV)) begin
            e_cs  = 1'b0;
            e_sck = ((j / DIV) % 2) != 0;
            check("pico", pmod_pico, acc_byte[7 - j / (2 * DIV)]);
         end
      end else begin
         check("pico_idle", pmod_pico, 1'b0);
      end
      check("cs", pmod_cs, e_cs);
      check("sck", pmod_sck, e_sck);
      check("dc", pmod_dc, acc_dc);
      check("tx_ready", tx_if.tx_ready, m_rdy(edge_n));
      check("pwr_ok", pwr_ok, m_pwr_ready(edge_n));
      check("pmoden", pmod_pmoden, en_edge >= 0);
      check("res", pmod_res, (en_edge >= 0) && (edge_n >= en_edge + T_VDD + T_RES));
      check("vccen", pmod_vccen, m_pwr_ready(edge_n) && vcc_s);
   endtask

   task automatic cycle();
      @(posedge clk0);
      edge_n++;
      model_edge();
      @(negedge clk0);
      compare();
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; vcc_on = 1'b0;
      tx_if.tx_valid = 1'b0; tx_if.tx_data = '0; tx_if.tx_dc = 1'b0;
      repeat (3) cycle();
      rst = 1'b0;
      cycle();

      // Bring-up with a byte and VCC already requested
      en = 1'b1; vcc_on = 1'b1; tx_if.tx_valid = 1'b1; tx_if.tx_data = 8'h3C;
      repeat (30) cycle();
      tx_if.tx_valid = 1'b0;
      repeat (40) cycle();

      // Single byte; data changes right after accept must not leak in
      tx_if.tx_valid = 1'b1; tx_if.tx_data = 8'hA5; tx_if.tx_dc = 1'b0;
      for (int i = 0; i < 40 && acc_edge != edge_n; i++) cycle();
      tx_if.tx_valid = 1'b0; tx_if.tx_data = 8'h5A; tx_if.tx_dc = 1'b1;
      repeat (40) cycle();

      // Back-to-back with valid held
      tx_if.tx_valid = 1'b1; tx_if.tx_data = 8'hAF; tx_if.tx_dc = 1'b0;
      for (int i = 0; i < 40 && acc_edge != edge_n; i++) cycle();
      tx_if.tx_data = 8'h12; tx_if.tx_dc = 1'b1;
      repeat (40) cycle();
      tx_if.tx_valid = 1'b0;
      repeat (5) cycle();

      // Random traffic, VCC requests, occasional en drops and resets
      for (int i = 0; i < 700; i++) begin
         tx_if.tx_valid = 1'($urandom_range(0, 1));
         tx_if.tx_data  = 8'($urandom);
         tx_if.tx_dc    = 1'($urandom_range(0, 1));
         vcc_on         = 1'($urandom_range(0, 1));
         en             = ($urandom_range(0, 40) != 0);
         rst            = ($urandom_range(0, 250) == 0);
         cycle();
      end
      rst = 1'b0; en = 1'b1; tx_if.tx_valid = 1'b0;
      repeat (70) cycle();

      // Reset three bits into a byte
      tx_if.tx_valid = 1'b1; tx_if.tx_data = 8'hC3;
      for (int i = 0; i < 40 && acc_edge != edge_n; i++) cycle();
      tx_if.tx_valid = 1'b0;
      repeat (1 + 6 * DIV) cycle();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      repeat (35) cycle();

      // Drop en while idle with VCC on
      vcc_on = 1'b1;
      repeat (3) cycle();
      en = 1'b0;
      repeat (40) cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
